// File: rtl/serial_tx.sv
// serial_tx: tick-paced asynchronous serial transmitter.
// Shifts a parallel word out LSB-first as start bit, data bits, optional
// parity bit and one or two stop bits. Each line bit lasts one iTick period;
// oLoad reloads the upstream baud divider on accept so the start bit gets a
// full period.
module serial_tx #(
    parameter int DATABITS   = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOPBITS   = 1
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iTick,
    input  logic [DATABITS-1:0] iData,
    input  logic                iValid,
    output logic                oReady,
    output logic                oLoad,
    output logic                oTx,
    output logic                oBusy,
    output logic                oDone
);

    localparam int            CW       = (DATABITS > 1) ? $clog2(DATABITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATABITS - 1);
    localparam logic          PAR_ON   = (PARITY_EN != 0);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);
    localparam logic          TWO_STOP = (STOPBITS == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity of a data word, optionally inverted for odd parity.
    function automatic logic f_parity(input logic [DATABITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_t                r_state;
    logic [DATABITS-1:0]   r_shift;
    logic [CW-1:0]         r_bitcnt;
    logic                  r_stopcnt;
    logic                  r_par;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    state_t                w_state_next;
    logic [DATABITS-1:0]   w_shift_next;
    logic [CW-1:0]         w_bitcnt_next;
    logic                  w_stopcnt_next;
    logic                  w_par_next;
    logic                  w_tx_next;
    logic                  w_busy_next;
    logic                  w_done_next;
    logic                  w_accept;
    logic                  w_last_stop;

    assign oReady      = (r_state == S_IDLE);
    assign w_accept    = iValid && (r_state == S_IDLE) && !iReset;
    assign oLoad       = w_accept;
    assign oTx         = r_tx;
    assign oBusy       = r_busy;
    assign oDone       = r_done;
    assign w_last_stop = TWO_STOP ? r_stopcnt : 1'b1;

    // State and datapath registers; reset forces an idle line immediately.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_stopcnt <= 1'b0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bitcnt  <= w_bitcnt_next;
            r_stopcnt <= w_stopcnt_next;
            r_par     <= w_par_next;
            r_tx      <= w_tx_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    // Next-state, datapath and frame-sequencing logic.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bitcnt_next  = r_bitcnt;
        w_stopcnt_next = r_stopcnt;
        w_par_next     = r_par;
        w_done_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next   = S_START;
                    w_shift_next   = iData;
                    w_par_next     = f_parity(iData, PAR_ODD);
                    w_bitcnt_next  = '0;
                    w_stopcnt_next = 1'b0;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_START: begin
                if (iTick) begin
                    w_state_next  = S_DATA;
                    w_bitcnt_next = '0;
                end else begin
                    w_state_next = S_START;
                end
            end
            S_DATA: begin
                if (iTick) begin
                    w_shift_next = {1'b0, r_shift[DATABITS-1:1]};
                    if (r_bitcnt == LAST_BIT) begin
                        w_stopcnt_next = 1'b0;
                        if (PAR_ON) begin
                            w_state_next = S_PARITY;
                        end else begin
                            w_state_next = S_STOP;
                        end
                    end else begin
                        w_bitcnt_next = r_bitcnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_state_next = S_DATA;
                end
            end
            S_PARITY: begin
                if (iTick) begin
                    w_state_next   = S_STOP;
                    w_stopcnt_next = 1'b0;
                end else begin
                    w_state_next = S_PARITY;
                end
            end
            S_STOP: begin
                if (iTick) begin
                    if (w_last_stop) begin
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_stopcnt_next = 1'b1;
                    end
                end else begin
                    w_state_next = S_STOP;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Registered line level and busy flag, derived from the upcoming state.
    always_comb begin
        w_tx_next   = 1'b1;
        w_busy_next = (w_state_next != S_IDLE);
        case (w_state_next)
            S_IDLE:   w_tx_next = 1'b1;
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = w_par_next;
            S_STOP:   w_tx_next = 1'b1;
            default:  w_tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx: four instances (8N1, 8E1, 8O1, 8N2), each paced by
// its own divide-by-4 tick model that is reloaded by the instance's oLoad.
module tb_serial_tx;

    logic       clk;
    logic       rst;
    logic [3:0] tick;
    logic [3:0] load;
    logic [3:0] valid;
    logic [3:0] ready;
    logic [3:0] tx;
    logic [3:0] busy;
    logic [3:0] done;
    logic [7:0] data [4];
    logic [1:0] div_cnt [4];

    int n_cmp;
    int n_err;

    serial_tx #(.DATABITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOPBITS(1)) u_8n1 (
        .iClk(clk), .iReset(rst), .iTick(tick[0]), .iData(data[0]), .iValid(valid[0]),
        .oReady(ready[0]), .oLoad(load[0]), .oTx(tx[0]), .oBusy(busy[0]), .oDone(done[0]));
    serial_tx #(.DATABITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOPBITS(1)) u_8e1 (
        .iClk(clk), .iReset(rst), .iTick(tick[1]), .iData(data[1]), .iValid(valid[1]),
        .oReady(ready[1]), .oLoad(load[1]), .oTx(tx[1]), .oBusy(busy[1]), .oDone(done[1]));
    serial_tx #(.DATABITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOPBITS(1)) u_8o1 (
        .iClk(clk), .iReset(rst), .iTick(tick[2]), .iData(data[2]), .iValid(valid[2]),
        .oReady(ready[2]), .oLoad(load[2]), .oTx(tx[2]), .oBusy(busy[2]), .oDone(done[2]));
    serial_tx #(.DATABITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOPBITS(2)) u_8n2 (
        .iClk(clk), .iReset(rst), .iTick(tick[3]), .iData(data[3]), .iValid(valid[3]),
        .oReady(ready[3]), .oLoad(load[3]), .oTx(tx[3]), .oBusy(busy[3]), .oDone(done[3]));

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud divider model: period of 4 cycles, reloaded by load.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                div_cnt[i] <= 2'd3;
            end else if (load[i] || div_cnt[i] == 2'd0) begin
                div_cnt[i] <= 2'd3;
            end else begin
                div_cnt[i] <= div_cnt[i] - 2'd1;
            end
        end
    end

    // Divider ready strobe.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            tick[i] = (div_cnt[i] == 2'd0);
        end
    end

    // Checks a frame starting at the first cycle after accept; returns at the
    // cycle in which oDone must be high, after checking it.
    task automatic run_frame(input int idx, input logic [0:11] bits, input int nbits,
                             input string name);
        for (int k = 0; k < nbits * 4; k++) begin
            n_cmp++;
            if (tx[idx] !== bits[k / 4]) begin
                n_err++;
                $display("FAIL %s tx cycle %0d: got %b want %b", name, k, tx[idx], bits[k / 4]);
            end
            n_cmp++;
            if ({busy[idx], done[idx], ready[idx], load[idx]} !== 4'b1000) begin
                n_err++;
                $display("FAIL %s busy/done/ready/load cycle %0d: got %b want 1000",
                         name, k, {busy[idx], done[idx], ready[idx], load[idx]});
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({done[idx], busy[idx], tx[idx], ready[idx]} !== 4'b1011) begin
            n_err++;
            $display("FAIL %s end done/busy/tx/ready: got %b want 1011",
                     name, {done[idx], busy[idx], tx[idx], ready[idx]});
        end
    endtask

    // Accepts one word on instance idx and checks the whole frame.
    task automatic send_frame(input int idx, input logic [7:0] d, input logic [0:11] bits,
                              input int nbits, input string name);
        @(negedge clk);
        data[idx]  = d;
        valid[idx] = 1'b1;
        #1;
        n_cmp++;
        if ({ready[idx], load[idx]} !== 2'b11) begin
            n_err++;
            $display("FAIL %s accept ready/load: got %b want 11", name, {ready[idx], load[idx]});
        end
        @(negedge clk);
        valid[idx] = 1'b0;
        #1;
        run_frame(idx, bits, nbits, name);
        n_cmp++;
        if (load[idx] !== 1'b0) begin
            n_err++;
            $display("FAIL %s load in done cycle: got %b want 0", name, load[idx]);
        end
        @(negedge clk);
        n_cmp++;
        if (done[idx] !== 1'b0) begin
            n_err++;
            $display("FAIL %s done width: got %b want 0", name, done[idx]);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        valid[0] = 1'b1;
        data[0]  = 8'h55;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({tx[i], ready[i], busy[i], done[i], load[i]} !== 5'b11000) begin
                n_err++;
                $display("FAIL reset inst %0d tx/ready/busy/done/load: got %b want 11000",
                         i, {tx[i], ready[i], busy[i], done[i], load[i]});
            end
        end
        valid[0] = 1'b0;
        rst      = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_8n1();
        send_frame(0, 8'hA5, 12'b0101_0010_1100, 10, "8n1_a5");
    endtask

    task automatic test_parity();
        send_frame(1, 8'h07, 12'b0111_0000_0110, 11, "8e1_07");
        send_frame(2, 8'h07, 12'b0111_0000_0010, 11, "8o1_07");
    endtask

    task automatic test_two_stop();
        send_frame(3, 8'hFF, 12'b0111_1111_1110, 11, "8n2_ff");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        data[0]  = 8'h3C;
        valid[0] = 1'b1;
        #1;
        n_cmp++;
        if (load[0] !== 1'b1) begin
            n_err++;
            $display("FAIL b2b first load: got %b want 1", load[0]);
        end
        @(negedge clk);
        data[0] = 8'hC3;
        #1;
        run_frame(0, 12'b0001_1110_0100, 10, "b2b_3c");
        n_cmp++;
        if ({load[0], ready[0]} !== 2'b11) begin
            n_err++;
            $display("FAIL b2b second accept load/ready: got %b want 11", {load[0], ready[0]});
        end
        @(negedge clk);
        valid[0] = 1'b0;
        #1;
        run_frame(0, 12'b0110_0001_1100, 10, "b2b_c3");
        @(negedge clk);
        n_cmp++;
        if ({done[0], tx[0], busy[0]} !== 3'b010) begin
            n_err++;
            $display("FAIL b2b after done/tx/busy: got %b want 010", {done[0], tx[0], busy[0]});
        end
    endtask

    task automatic test_idle_and_hold();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({tx[0], busy[0], done[0]} !== 3'b100) begin
                n_err++;
                $display("FAIL idle ticks cycle %0d tx/busy/done: got %b want 100",
                         k, {tx[0], busy[0], done[0]});
            end
        end
        @(negedge clk);
        data[0]  = 8'h5A;
        valid[0] = 1'b1;
        #1;
        @(negedge clk);
        valid[0] = 1'b0;
        data[0]  = 8'hFF;
        #1;
        run_frame(0, 12'b0010_1101_0100, 10, "hold_5a");
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        data[0]  = 8'hA5;
        valid[0] = 1'b1;
        #1;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (tx[0] !== 1'b0) begin
            n_err++;
            $display("FAIL midrst start bit: got %b want 0", tx[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({tx[0], busy[0], ready[0]} !== 3'b101) begin
            n_err++;
            $display("FAIL midrst async tx/busy/ready: got %b want 101", {tx[0], busy[0], ready[0]});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({done[0], tx[0]} !== 2'b01) begin
                n_err++;
                $display("FAIL midrst after cycle %0d done/tx: got %b want 01", k, {done[0], tx[0]});
            end
        end
    endtask

    // Test sequence.
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            data[i] = 8'h00;
        end
        test_reset();
        test_8n1();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_idle_and_hold();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Tick-paced asynchronous serial transmitter; sits directly downstream of the reloadable down-counter/baud divider.
- Consumes the divider's one-cycle ready strobe as its bit-time enable.
- Drives the divider's load input on each frame accept, so every frame starts on a full bit period.
- Accepts parallel words through a valid/ready handshake and shifts them out LSB-first: start bit, data bits, optional parity, stop bits.

Parameters:
- DATABITS, 8, data word width; legal range 5..9.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOPBITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- iClk  input  1  system clock; all logic on its rising edge.
- iReset  input  1  asynchronous, active-high reset.
- iTick  input  1  bit-time strobe (divider ready output); one cycle high per bit period.
- iData  input  DATABITS  word to transmit; sampled only on accept.
- iValid  input  1  iData valid; hold until accepted.
- oReady  output  1  high when the block can accept; equals (state==IDLE).
- oLoad  output  1  one-cycle pulse in the accept cycle (combinational iValid&&oReady); drives divider iLoad.
- oTx  output  1  serial line, registered; idle level 1.
- oBusy  output  1  high in every state except IDLE, registered.
- oDone  output  1  one-cycle pulse after the last stop bit completes, registered.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high. While iReset is high: state=IDLE, oTx=1, oBusy=0, oDone=0, shift register=0, bit count=0. oReady=1 and oLoad=0 (iValid is ignored during reset).
- Reset mid-frame: the frame is aborted immediately and oTx returns to 1 asynchronously. No oDone is issued.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - oTx=1. iTick is ignored.
  - Accept occurs when iValid && oReady. In that cycle: oLoad=1, iData is latched into the shift register, parity is computed from iData, state becomes START.
  - oTx=0 from the next cycle.
- START: oTx=0. On iTick, go to DATA with bit count=0.
- DATA:
  - oTx = shift register LSB.
  - On iTick: shift right by one, increment bit count.
  - When the count reaches DATABITS-1 on a tick, go to PARITY if PARITY_EN, else STOP.
- PARITY: oTx = XOR of the latched data, XOR PARITY_ODD. On iTick, go to STOP.
- STOP:
  - oTx=1. A stop counter counts ticks.
  - On the STOPBITS-th tick, go to IDLE and register oDone=1 for exactly the following cycle.
  - oReady is high in that same cycle, so a new word may be accepted while oDone is high (back-to-back frames, zero idle gap).
- Bit timing:
  - Every line bit, including the start bit, lasts exactly one tick period.
  - The divider is reloaded by oLoad, so its first strobe arrives one full period after accept.
  - Line transitions occur one cycle after the tick that ends the previous bit.
- Frame length: 1 + DATABITS + PARITY_EN + STOPBITS tick periods.
- iData and iValid changes while busy have no effect. Latched data is immune to input changes.
- iTick in the accept cycle is ignored; the state is still IDLE in that cycle.
- Width rules:
  - Bit counter is $clog2(DATABITS) bits wide; compare against DATABITS-1, no wrap.
  - Stop counter is 1 bit wide.
- Unused or illegal state encodings recover to IDLE on the next clock.

Test Plan:
- Reset → oTx=1, oReady=1, oBusy=0, oDone=0. Assert iReset mid-frame → oTx=1 within the same cycle, no oDone afterwards.
- 8N1, tick every 4 cycles, iData=0xA5 → oLoad pulses once. oTx is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles long. oDone rises 40 cycles after accept+1. oBusy is high for 40 cycles.
- PARITY_EN=1, PARITY_ODD=0, iData=0x07 → parity bit=1. With PARITY_ODD=1 → parity bit=0. Frame is 11 bit times.
- STOPBITS=2, iData=0xFF → 2 stop-bit periods of 1. oDone arrives after the second stop tick only.
- Back-to-back: iValid held high with 0x3C then 0xC3 → second accept in the oDone cycle. Start bit of the second frame immediately follows the stop bit, with no extra idle cycles.
- Ticks while idle and an iData change mid-frame → no line activity while idle. The transmitted frame matches the originally latched word.
